// File: rtl/fifo_flush_pkg.sv
// Shared types and width helpers for the flush-packing FIFO.
package fifo_flush_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  function automatic int min_u(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_pack_lane_sel.sv
// One output lane of the packed word: the entry lane_idx places past rd_ptr, or PAD
// when the lane lies beyond the snapshot length n.
module fifo_pack_lane_sel
  import fifo_flush_pkg::*;
#(
  parameter int                DATA_W = 4,
  parameter int                PACK   = 8,
  parameter int                DEPTH  = 32,
  parameter logic [DATA_W-1:0] PAD    = 4'hC
) (
  input  logic [DEPTH*DATA_W-1:0]  mem_flat,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [cnt_w(PACK)-1:0]   lane_idx,
  input  logic [cnt_w(PACK)-1:0]   n,
  output logic [DATA_W-1:0]        lane_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] addr_s;

  // Address wraps naturally because DEPTH is a power of two
  always_comb begin
    addr_s = rd_ptr + AW'(lane_idx);
    if (lane_idx < n) begin
      lane_data = mem_flat[addr_s*DATA_W +: DATA_W];
    end else begin
      lane_data = PAD;
    end
  end

endmodule

// File: rtl/fifo_flush_pack.sv
// Single-clock FIFO that packs up to PACK oldest entries into one wide word on flush.
// Optional build macro FIFO_FLUSH_AUTO_EN: flush automatically whenever PACK entries are held.
module fifo_flush_pack
  import fifo_flush_pkg::*;
#(
  parameter int                DATA_W = 4,
  parameter int                PACK   = 8,
  parameter int                DEPTH  = 32,
  parameter logic [DATA_W-1:0] PAD    = 4'hC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fifo_wr_valid_i,
  input  logic [DATA_W-1:0]         fifo_wr_data_i,
  input  logic                      fifo_flush_i,
  output logic                      fifo_flush_rdy_o,
  output logic                      fifo_rd_valid_o,
  input  logic                      fifo_rd_ready_i,
  output logic [PACK*DATA_W-1:0]    fifo_rd_data_o,
  output logic [cnt_w(PACK)-1:0]    fifo_rd_count_o,
  output logic [cnt_w(DEPTH)-1:0]   fifo_count_o,
  output logic                      fifo_empty_o,
  output logic                      fifo_full_o,
  output logic                      fifo_ovf_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int RCNT_W = cnt_w(PACK);

  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat_s;
  logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [PACK*DATA_W-1:0]  rd_data_r, lanes_s;
  logic [RCNT_W-1:0]       rd_count_r, n_s, n_pop_s;
  logic                    rd_valid_r, ovf_r;
  logic                    full_s, wr_acc_s, auto_s, flush_req_s, pop_s;
  state_t                  state_r, state_nxt_s;

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign wr_acc_s = fifo_wr_valid_i & ~full_s;
  assign n_s      = RCNT_W'(min_u(PACK, int'(count_r)));
  assign n_pop_s  = pop_s ? n_s : {RCNT_W{1'b0}};

`ifdef FIFO_FLUSH_AUTO_EN
  assign auto_s = (count_r >= CNT_W'(PACK));
`else
  assign auto_s = 1'b0;
`endif

  assign flush_req_s = fifo_flush_i | auto_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat_s[g*DATA_W +: DATA_W] = mem_r[g];
  end

  for (genvar l = 0; l < PACK; l++) begin : g_lane
    fifo_pack_lane_sel #(
      .DATA_W(DATA_W), .PACK(PACK), .DEPTH(DEPTH), .PAD(PAD)
    ) u_lane (
      .mem_flat  (mem_flat_s),
      .rd_ptr    (rd_ptr_r),
      .lane_idx  (RCNT_W'(l)),
      .n         (n_s),
      .lane_data (lanes_s[l*DATA_W +: DATA_W])
    );
  end

  // Storage array: deliberately not cleared by reset
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= fifo_wr_data_i;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a flush raised while PRESENT is dropped, not queued
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush_req_s) begin
          state_nxt_s = PRESENT;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESENT: begin
        if (fifo_rd_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Pointers, occupancy, sticky overflow and the held output word
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_data_r  <= {(PACK*DATA_W){1'b0}};
      rd_count_r <= {RCNT_W{1'b0}};
      rd_valid_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (fifo_wr_valid_i && full_s) begin
        ovf_r <= 1'b1;
      end
      // full is judged on the pre-pop count, so a pop never frees room this cycle
      count_r <= count_r - CNT_W'(n_pop_s) + CNT_W'(wr_acc_s);
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + AW'(n_s);
        rd_data_r  <= lanes_s;
        rd_count_r <= n_s;
        rd_valid_r <= 1'b1;
      end else if ((state_r == PRESENT) && fifo_rd_ready_i) begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  assign fifo_flush_rdy_o = (state_r == IDLE);
  assign fifo_rd_valid_o  = rd_valid_r;
  assign fifo_rd_data_o   = rd_data_r;
  assign fifo_rd_count_o  = rd_count_r;
  assign fifo_count_o     = count_r;
  assign fifo_empty_o     = (count_r == {CNT_W{1'b0}});
  assign fifo_full_o      = full_s;
  assign fifo_ovf_o       = ovf_r;

endmodule

// File: tb/tb_fifo_flush_pack.sv
// Directed, table-driven bench for fifo_flush_pack (DATA_W=4, PACK=8, DEPTH=32, PAD=4'hC).
module tb_fifo_flush_pack;

  logic        clock = 1'b0;
  logic        reset, wv, fl, rdy;
  logic [3:0]  wd;
  logic        frdy, rv, empty, full, ovf;
  logic [31:0] rdata;
  logic [3:0]  rcnt;
  logic [5:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic eovf = 1'b0;

  fifo_flush_pack dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_wr_valid_i (wv),
    .fifo_wr_data_i  (wd),
    .fifo_flush_i    (fl),
    .fifo_flush_rdy_o(frdy),
    .fifo_rd_valid_o (rv),
    .fifo_rd_ready_i (rdy),
    .fifo_rd_data_o  (rdata),
    .fifo_rd_count_o (rcnt),
    .fifo_count_o    (cnt),
    .fifo_empty_o    (empty),
    .fifo_full_o     (full),
    .fifo_ovf_o      (ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wv;
    logic [3:0]  wd;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  erc;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [3:0] d, logic f, logic r,
                              logic ev, logic [31:0] ed, logic [3:0] erc, logic [5:0] ecnt);
    vec_t v;
    v.wv = w; v.wd = d; v.fl = f; v.rdy = r;
    v.ev = ev; v.ed = ed; v.erc = erc; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ed,
                         input logic [3:0] erc, input logic [5:0] ecnt);
    chk({tag, ".rd_valid"}, 32'(rv), 32'(ev));
    chk({tag, ".rd_data"},  rdata, ed);
    chk({tag, ".rd_count"}, 32'(rcnt), 32'(erc));
    chk({tag, ".count"},    32'(cnt), 32'(ecnt));
    chk({tag, ".empty"},    32'(empty), 32'(ecnt == 6'd0));
    chk({tag, ".full"},     32'(full), 32'(ecnt == 6'd32));
    chk({tag, ".ovf"},      32'(ovf), 32'(eovf));
    chk({tag, ".flush_rdy"}, 32'(frdy), 32'(!ev));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] d, input logic f, input logic r);
    wv = w; wd = d; fl = f; rdy = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus table: writes 1,2,3 then flush/accept; 0..9 then two flushes; empty flush
    tbl.push_back(mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 6'd1));
    tbl.push_back(mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 6'd2));
    tbl.push_back(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 6'd3));
    tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hCCCCC321, 4'd3, 6'd0));
    tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hCCCCC321, 4'd3, 6'd0));
`ifndef FIFO_FLUSH_AUTO_EN
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk(1'b1, i[3:0], 1'b0, 1'b0, 1'b0, 32'hCCCCC321, 4'd3, 6'(i + 1)));
    end
    tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h76543210, 4'd8, 6'd2));
    tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h76543210, 4'd8, 6'd2));
    tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hCCCCCC98, 4'd2, 6'd0));
    tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hCCCCCC98, 4'd2, 6'd0));
`endif
    tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 4'd0, 6'd0));
    tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hCCCCCCCC, 4'd0, 6'd0));

    reset = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("reset", 1'b0, 32'h0, 4'd0, 6'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].erc, tbl[i].ecnt);
    end

`ifndef FIFO_FLUSH_AUTO_EN
    // Fill to full from pointer 13 so later gathers wrap past the storage end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, i[3:0], 1'b0, 1'b0);
      tick();
    end
    chk_all("fill32", 1'b0, 32'hCCCCCCCC, 4'd0, 6'd32);
    drive(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    eovf = 1'b1;
    chk_all("wr33", 1'b0, 32'hCCCCCCCC, 4'd0, 6'd32);

    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("ovf_flush1", 1'b1, 32'h76543210, 4'd8, 6'd24);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("ovf_flush2", 1'b1, 32'hFEDCBA98, 4'd8, 6'd16);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("wrap_flush", 1'b1, 32'h76543210, 4'd8, 6'd8);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Backpressure: word held for 5 cycles, a flush pulse in PRESENT is dropped
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("hold0", 1'b1, 32'hFEDCBA98, 4'd8, 6'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'h0, (k == 2), 1'b0);
      tick();
      chk_all($sformatf("hold%0d", k + 1), 1'b1, 32'hFEDCBA98, 4'd8, 6'd0);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();
    chk_all("hold_acc", 1'b0, 32'hFEDCBA98, 4'd8, 6'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0); tick();
    chk_all("no_queue", 1'b0, 32'hFEDCBA98, 4'd8, 6'd0);

    // Same-cycle write and flush: snapshot excludes the new entry
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i[3:0], 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'hA, 1'b1, 1'b0); tick();
    chk_all("wr_flush", 1'b1, 32'h87654321, 4'd8, 6'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("after_wr_flush", 1'b1, 32'hCCCCCCCA, 4'd1, 6'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();

    // Reset while a word is pending discards it
    drive(1'b1, 4'h3, 1'b0, 1'b0); tick();
    drive(1'b0, 4'h0, 1'b1, 1'b0); tick();
    chk_all("pre_reset", 1'b1, 32'hCCCCCCC3, 4'd1, 6'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    eovf = 1'b0;
    chk_all("reset_present", 1'b0, 32'h0, 4'd0, 6'd0);
    reset = 1'b0;
`else
    // Auto flush: PACK entries trigger a full word with no flush request
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[3:0], 1'b0, 1'b0);
      tick();
    end
    chk_all("auto_fill", 1'b0, 32'hCCCCCCCC, 4'd0, 6'd8);
    drive(1'b0, 4'h0, 1'b0, 1'b0); tick();
    chk_all("auto_word", 1'b1, 32'h76543210, 4'd8, 6'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b1); tick();
    chk_all("auto_acc", 1'b0, 32'h76543210, 4'd8, 6'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
